// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I decode definitions: opcodes, funct7 encodings,
//               ALU operation codes, ALU operand-select codes, decode-stage
//               state enum, control-bit bundle and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

   // Major opcodes
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;

   // funct7 encodings
   localparam logic [6:0] c_F7_BASE   = 7'b0000000;
   localparam logic [6:0] c_F7_ALT    = 7'b0100000;
   localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

   // ALU operation codes
   localparam int c_ALU_NONE = 0;
   localparam int c_ALU_ADD  = 1;
   localparam int c_ALU_SUB  = 2;
   localparam int c_ALU_SLT  = 3;
   localparam int c_ALU_SLTU = 4;
   localparam int c_ALU_BEQ  = 5;
   localparam int c_ALU_BNE  = 6;
   localparam int c_ALU_BLT  = 7;
   localparam int c_ALU_BGE  = 8;
   localparam int c_ALU_BLTU = 9;
   localparam int c_ALU_BGEU = 10;
   localparam int c_ALU_AND  = 11;
   localparam int c_ALU_OR   = 12;
   localparam int c_ALU_XOR  = 13;
   localparam int c_ALU_SLL  = 14;
   localparam int c_ALU_SRL  = 15;
   localparam int c_ALU_SRA  = 16;
   localparam int c_ALU_MUL  = 17;   // MUL..REMU occupy 17..24 in funct3 order

   // ALU operand selects
   localparam int c_SRC1_RS1   = 0;
   localparam int c_SRC1_PC    = 1;
   localparam int c_SRC1_ZERO  = 2;
   localparam int c_SRC2_RS2   = 0;
   localparam int c_SRC2_IIMM  = 1;
   localparam int c_SRC2_SHAMT = 2;
   localparam int c_SRC2_SIMM  = 3;
   localparam int c_SRC2_UIMM  = 4;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

   typedef struct packed {
      logic jal;
      logic jalr;
      logic jumpregwrite;
      logic branch;
      logic memwrite;
      logic memenable;
      logic regwrite;
      logic memtoreg;
   } ctrl_t;

   // ALU code shared by OP and OP-IMM for the base (funct7=0) encodings
   function automatic int base_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return c_ALU_ADD;
         3'b001:  return c_ALU_SLL;
         3'b010:  return c_ALU_SLT;
         3'b011:  return c_ALU_SLTU;
         3'b100:  return c_ALU_XOR;
         3'b101:  return c_ALU_SRL;
         3'b110:  return c_ALU_OR;
         default: return c_ALU_AND;
      endcase
   endfunction

   // Formats whose rs1 field is a real source register
   function automatic logic reads_rs1(input logic [6:0] opc);
      return (opc == c_OPC_JALR)  || (opc == c_OPC_BRANCH) ||
             (opc == c_OPC_LOAD)  || (opc == c_OPC_STORE)  ||
             (opc == c_OPC_OPIMM) || (opc == c_OPC_OP);
   endfunction

   // Formats whose rs2 field is a real source register
   function automatic logic reads_rs2(input logic [6:0] opc);
      return (opc == c_OPC_OP) || (opc == c_OPC_BRANCH) || (opc == c_OPC_STORE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode_comb
// Description : Purely combinational RV32I(M) instruction decoder.
//   ins      in   32        instruction word
//   ctrl     out  ctrl_t    control bits (jal, jalr, jumpregwrite, branch,
//                           memwrite, memenable, regwrite, memtoreg)
//   aluop    out  ALUOP_W   ALU operation code
//   alusrc1  out  SRC_W     ALU operand 1 select
//   alusrc2  out  SRC_W     ALU operand 2 select
//   rs1/rs2/rd out 5        raw register index fields
//   illegal  out  1         instruction is not a legal encoding
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode_comb
   import rv32i_pkg::*;
#(
   parameter int ALUOP_W = 6,
   parameter int SRC_W   = 4,
   parameter int M_EXT   = 0,
   parameter int STRICT  = 1
) (
   input  logic [31:0]        ins,
   output ctrl_t              ctrl,
   output logic [ALUOP_W-1:0] aluop,
   output logic [SRC_W-1:0]   alusrc1,
   output logic [SRC_W-1:0]   alusrc2,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic               illegal
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   ctrl_t      w_ctrl;
   int         w_op;
   int         w_s1;
   int         w_s2;
   logic       w_ill;

   assign w_opc = ins[6:0];
   assign w_f3  = ins[14:12];
   assign w_f7  = ins[31:25];
   assign rd    = ins[11:7];
   assign rs1   = ins[19:15];
   assign rs2   = ins[24:20];

   always_comb begin
      w_ctrl = '0;
      w_op   = c_ALU_NONE;
      w_s1   = c_SRC1_RS1;
      w_s2   = c_SRC2_RS2;
      w_ill  = 1'b0;
      case (w_opc)
         c_OPC_LUI: begin
            w_ctrl.regwrite = 1'b1;
            w_op = c_ALU_ADD;
            w_s1 = c_SRC1_ZERO;
            w_s2 = c_SRC2_UIMM;
         end
         c_OPC_AUIPC: begin
            w_ctrl.regwrite = 1'b1;
            w_op = c_ALU_ADD;
            w_s1 = c_SRC1_PC;
            w_s2 = c_SRC2_UIMM;
         end
         c_OPC_JAL: begin
            w_ctrl.jal          = 1'b1;
            w_ctrl.jumpregwrite = 1'b1;
            w_op = c_ALU_ADD;
            w_s1 = c_SRC1_PC;
         end
         c_OPC_JALR: begin
            w_ctrl.jalr         = 1'b1;
            w_ctrl.jumpregwrite = 1'b1;
            w_op = c_ALU_ADD;
            w_s2 = c_SRC2_IIMM;
            w_ill = (w_f3 != 3'b000);
         end
         c_OPC_BRANCH: begin
            w_ctrl.branch = 1'b1;
            case (w_f3)
               3'b000:  w_op = c_ALU_BEQ;
               3'b001:  w_op = c_ALU_BNE;
               3'b100:  w_op = c_ALU_BLT;
               3'b101:  w_op = c_ALU_BGE;
               3'b110:  w_op = c_ALU_BLTU;
               3'b111:  w_op = c_ALU_BGEU;
               default: w_ill = 1'b1;
            endcase
         end
         c_OPC_LOAD: begin
            w_ctrl.memenable = 1'b1;
            w_ctrl.regwrite  = 1'b1;
            w_ctrl.memtoreg  = 1'b1;
            w_op = c_ALU_ADD;
            w_s2 = c_SRC2_IIMM;
            w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         c_OPC_STORE: begin
            w_ctrl.memwrite  = 1'b1;
            w_ctrl.memenable = 1'b1;
            w_op = c_ALU_ADD;
            w_s2 = c_SRC2_SIMM;
            w_ill = (w_f3 > 3'b010);
         end
         c_OPC_OPIMM: begin
            w_ctrl.regwrite = 1'b1;
            w_op = base_alu(w_f3);
            w_s2 = c_SRC2_IIMM;
            if (w_f3 == 3'b001) begin
               w_s2 = c_SRC2_SHAMT;
               if ((STRICT != 0) && (w_f7 != c_F7_BASE)) w_ill = 1'b1;
            end
            if (w_f3 == 3'b101) begin
               w_s2 = c_SRC2_SHAMT;
               if (w_f7[5]) w_op = c_ALU_SRA;
               if ((STRICT != 0) && (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT)) w_ill = 1'b1;
            end
         end
         c_OPC_OP: begin
            w_ctrl.regwrite = 1'b1;
            if (w_f7 == c_F7_MULDIV) begin
               if (M_EXT != 0) w_op = c_ALU_MUL + int'(w_f3);
               else            w_ill = 1'b1;
            end else begin
               w_op = base_alu(w_f3);
               if (w_f7[5] && (w_f3 == 3'b000)) w_op = c_ALU_SUB;
               if (w_f7[5] && (w_f3 == 3'b101)) w_op = c_ALU_SRA;
               if (STRICT != 0) begin
                  if (w_f7 == c_F7_ALT) begin
                     if ((w_f3 != 3'b000) && (w_f3 != 3'b101)) w_ill = 1'b1;
                  end else if (w_f7 != c_F7_BASE) begin
                     w_ill = 1'b1;
                  end
               end
            end
         end
         default: w_ill = 1'b1;
      endcase

      // Writes to x0 are architecturally discarded; suppress them here
      if (ins[11:7] == 5'd0) begin
         w_ctrl.regwrite     = 1'b0;
         w_ctrl.jumpregwrite = 1'b0;
      end

      if (w_ill) begin
         w_ctrl = '0;
         w_op   = c_ALU_NONE;
         w_s1   = c_SRC1_RS1;
         w_s2   = c_SRC2_RS2;
      end
   end

   assign ctrl    = w_ctrl;
   assign aluop   = ALUOP_W'(w_op);
   assign alusrc1 = SRC_W'(w_s1);
   assign alusrc2 = SRC_W'(w_s2);
   assign illegal = w_ill;

endmodule
`default_nettype wire

// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode_stage
// Description : RV32I decode pipeline stage with a one-entry output register,
//               load-use bubble insertion, flush, and an illegal counter.
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop held/pending instruction, block accept
//   in_valid/in_ready fetch handshake; in_ins, in_pc instruction and PC
//   out_valid/out_ready execute handshake
//   out_pc, out_rs1, out_rs2, out_rd, control bits, out_aluop,
//   out_alusrc1, out_alusrc2, out_illegal   registered decoded bundle
//   illegal_cnt       saturating count of accepted illegal instructions
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode_stage
   import rv32i_pkg::*;
#(
   parameter int ALUOP_W = 6,
   parameter int SRC_W   = 4,
   parameter int M_EXT   = 0,
   parameter int STRICT  = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_ins,
   input  logic [31:0]        in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_pc,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [4:0]         out_rd,
   output logic               out_jal,
   output logic               out_jalr,
   output logic               out_jumpregwrite,
   output logic               out_branch,
   output logic               out_memwrite,
   output logic               out_memenable,
   output logic               out_regwrite,
   output logic               out_memtoreg,
   output logic [ALUOP_W-1:0] out_aluop,
   output logic [SRC_W-1:0]   out_alusrc1,
   output logic [SRC_W-1:0]   out_alusrc2,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   illegal_cnt
);

   state_t             r_state;
   logic [31:0]        r_pend_ins;
   logic [31:0]        r_pend_pc;
   logic               r_out_valid;
   logic [31:0]        r_pc;
   logic [4:0]         r_rs1, r_rs2, r_rd;
   ctrl_t              r_ctrl;
   logic [ALUOP_W-1:0] r_aluop;
   logic [SRC_W-1:0]   r_src1, r_src2;
   logic               r_illegal;
   logic [CNT_W-1:0]   r_illegal_cnt;

   logic [31:0]        w_sel_ins, w_sel_pc;
   ctrl_t              w_ctrl;
   logic [ALUOP_W-1:0] w_aluop;
   logic [SRC_W-1:0]   w_src1, w_src2;
   logic [4:0]         w_rs1, w_rs2, w_rd;
   logic               w_illegal;
   logic               w_accept, w_load_use, w_hazard, w_load;

   // During BUBBLE the decoder works on the parked instruction
   assign w_sel_ins = (r_state == ST_BUBBLE) ? r_pend_ins : in_ins;
   assign w_sel_pc  = (r_state == ST_BUBBLE) ? r_pend_pc  : in_pc;

   rv32i_decode_comb #(
      .ALUOP_W (ALUOP_W),
      .SRC_W   (SRC_W),
      .M_EXT   (M_EXT),
      .STRICT  (STRICT)
   ) u_decode (
      .ins     (w_sel_ins),
      .ctrl    (w_ctrl),
      .aluop   (w_aluop),
      .alusrc1 (w_src1),
      .alusrc2 (w_src2),
      .rs1     (w_rs1),
      .rs2     (w_rs2),
      .rd      (w_rd),
      .illegal (w_illegal)
   );

   assign in_ready = !flush && (r_state == ST_RUN) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Held legal load leaving this cycle whose rd feeds the incoming instruction
   assign w_load_use = r_out_valid && out_ready && r_ctrl.memtoreg && (r_rd != 5'd0) &&
                       ((reads_rs1(in_ins[6:0]) && (in_ins[19:15] == r_rd)) ||
                        (reads_rs2(in_ins[6:0]) && (in_ins[24:20] == r_rd)));
   assign w_hazard = w_accept && w_load_use;
   assign w_load   = !flush && ((r_state == ST_BUBBLE) || (w_accept && !w_hazard));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_out_valid   <= 1'b0;
         r_pend_ins    <= '0;
         r_pend_pc     <= '0;
         r_illegal_cnt <= '0;
      end else begin
         if (flush) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
            r_pend_ins  <= '0;
            r_pend_pc   <= '0;
         end else if (r_state == ST_BUBBLE) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b1;
            r_pend_ins  <= '0;
            r_pend_pc   <= '0;
         end else if (w_hazard) begin
            r_state     <= ST_BUBBLE;
            r_out_valid <= 1'b0;
            r_pend_ins  <= in_ins;
            r_pend_pc   <= in_pc;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept && w_illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_ctrl    <= '0;
         r_aluop   <= '0;
         r_src1    <= '0;
         r_src2    <= '0;
         r_illegal <= 1'b0;
      end else if (w_load) begin
         r_pc      <= w_sel_pc;
         r_rs1     <= w_rs1;
         r_rs2     <= w_rs2;
         r_rd      <= w_rd;
         r_ctrl    <= w_ctrl;
         r_aluop   <= w_aluop;
         r_src1    <= w_src1;
         r_src2    <= w_src2;
         r_illegal <= w_illegal;
      end
   end

   assign out_valid        = r_out_valid;
   assign out_pc           = r_pc;
   assign out_rs1          = r_rs1;
   assign out_rs2          = r_rs2;
   assign out_rd           = r_rd;
   assign out_jal          = r_ctrl.jal;
   assign out_jalr         = r_ctrl.jalr;
   assign out_jumpregwrite = r_ctrl.jumpregwrite;
   assign out_branch       = r_ctrl.branch;
   assign out_memwrite     = r_ctrl.memwrite;
   assign out_memenable    = r_ctrl.memenable;
   assign out_regwrite     = r_ctrl.regwrite;
   assign out_memtoreg     = r_ctrl.memtoreg;
   assign out_aluop        = r_aluop;
   assign out_alusrc1      = r_src1;
   assign out_alusrc2      = r_src2;
   assign out_illegal      = r_illegal;
   assign illegal_cnt      = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_decode_stage
// Description : Self-checking bench for rv32i_decode_stage. Two instances
//               share stimulus: u_dut0 (M_EXT=0) and u_dut1 (M_EXT=1), both
//               with CNT_W=4. A reference decoder and cycle model predict
//               every output each cycle; directed literal checks pin the
//               model on the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_ins = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b0;

   wire        rdy0, vld0, jal0, jalr0, jrw0, br0, mw0, me0, rw0, mtr0, ill0;
   wire        rdy1, vld1, jal1, jalr1, jrw1, br1, mw1, me1, rw1, mtr1, ill1;
   wire [31:0] pc0, pc1;
   wire [4:0]  rs10, rs20, rd0, rs11, rs21, rd1;
   wire [5:0]  aluop0, aluop1;
   wire [3:0]  sa0, sb0, sa1, sb1, cnt0, cnt1;

   rv32i_decode_stage #(.ALUOP_W(6), .SRC_W(4), .M_EXT(0), .STRICT(1), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
      .in_ins(in_ins), .in_pc(in_pc), .out_valid(vld0), .out_ready(out_ready),
      .out_pc(pc0), .out_rs1(rs10), .out_rs2(rs20), .out_rd(rd0),
      .out_jal(jal0), .out_jalr(jalr0), .out_jumpregwrite(jrw0), .out_branch(br0),
      .out_memwrite(mw0), .out_memenable(me0), .out_regwrite(rw0), .out_memtoreg(mtr0),
      .out_aluop(aluop0), .out_alusrc1(sa0), .out_alusrc2(sb0), .out_illegal(ill0),
      .illegal_cnt(cnt0));

   rv32i_decode_stage #(.ALUOP_W(6), .SRC_W(4), .M_EXT(1), .STRICT(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .in_ins(in_ins), .in_pc(in_pc), .out_valid(vld1), .out_ready(out_ready),
      .out_pc(pc1), .out_rs1(rs11), .out_rs2(rs21), .out_rd(rd1),
      .out_jal(jal1), .out_jalr(jalr1), .out_jumpregwrite(jrw1), .out_branch(br1),
      .out_memwrite(mw1), .out_memenable(me1), .out_regwrite(rw1), .out_memtoreg(mtr1),
      .out_aluop(aluop1), .out_alusrc1(sa1), .out_alusrc2(sb1), .out_illegal(ill1),
      .illegal_cnt(cnt1));

   always #5 clk = ~clk;

   wire [22:0] bun0 = {ill0, jal0, jalr0, jrw0, br0, mw0, me0, rw0, mtr0, aluop0, sa0, sb0};
   wire [22:0] bun1 = {ill1, jal1, jalr1, jrw1, br1, mw1, me1, rw1, mtr1, aluop1, sa1, sb1};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decoder: {illegal, jal, jalr, jumpregwrite, branch, memwrite,
   // memenable, regwrite, memtoreg, aluop[5:0], alusrc1[3:0], alusrc2[3:0]}
   function automatic logic [22:0] ref_decode(input logic [31:0] ins, input bit m);
      logic [6:0] opc, f7;
      logic [2:0] f3;
      int alu, s1, s2;
      int op_tab[8];
      int br_tab[8];
      bit ill, jal, jalr, jrw, br, mw, me, rw, mtr;
      op_tab = '{1, 14, 3, 4, 13, 15, 12, 11};
      br_tab = '{5, 6, 0, 0, 7, 8, 9, 10};
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      alu = 0; s1 = 0; s2 = 0;
      ill = 0; jal = 0; jalr = 0; jrw = 0; br = 0; mw = 0; me = 0; rw = 0; mtr = 0;
      case (opc)
         7'h37: begin rw = 1; alu = 1; s1 = 2; s2 = 4; end
         7'h17: begin rw = 1; alu = 1; s1 = 1; s2 = 4; end
         7'h6F: begin jal = 1; jrw = 1; alu = 1; s1 = 1; end
         7'h67: begin jalr = 1; jrw = 1; alu = 1; s2 = 1; ill = (f3 != 0); end
         7'h63: begin br = 1; alu = br_tab[f3]; ill = (alu == 0); end
         7'h03: begin me = 1; rw = 1; mtr = 1; alu = 1; s2 = 1; ill = (f3 == 3 || f3 == 6 || f3 == 7); end
         7'h23: begin mw = 1; me = 1; alu = 1; s2 = 3; ill = (f3 > 2); end
         7'h13: begin
            rw = 1; alu = op_tab[f3]; s2 = 1;
            if (f3 == 1) begin s2 = 2; ill = (f7 != 0); end
            if (f3 == 5) begin
               s2 = 2;
               if (f7 == 7'h20) alu = 16;
               else if (f7 != 0) ill = 1;
            end
         end
         7'h33: begin
            rw = 1;
            if (f7 == 0) alu = op_tab[f3];
            else if (f7 == 7'h20 && f3 == 0) alu = 2;
            else if (f7 == 7'h20 && f3 == 5) alu = 16;
            else if (f7 == 7'h01 && m) alu = 17 + int'(f3);
            else ill = 1;
         end
         default: ill = 1;
      endcase
      if (ins[11:7] == 0) begin rw = 0; jrw = 0; end
      if (ill) return {1'b1, 22'd0};
      return {1'b0, jal, jalr, jrw, br, mw, me, rw, mtr, 6'(alu), 4'(s1), 4'(s2)};
   endfunction

   function automatic bit needs_rs1(input logic [31:0] i);
      return i[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction
   function automatic bit needs_rs2(input logic [31:0] i);
      return i[6:0] inside {7'h33, 7'h63, 7'h23};
   endfunction

   // Cycle model of the stage
   bit          m_valid = 0, m_bub = 0;
   logic [31:0] m_held = '0, m_hpc = '0, m_pend = '0, m_ppc = '0;
   int          m_cnt0 = 0, m_cnt1 = 0;

   always @(posedge clk) begin
      bit rdy, acc, cons, haz, held_load;
      logic [22:0] dh, d0, d1;
      if (!rst_n) begin
         m_valid = 0; m_bub = 0; m_held = '0; m_hpc = '0; m_pend = '0; m_ppc = '0;
         m_cnt0 = 0; m_cnt1 = 0;
      end else begin
         rdy  = !flush && !m_bub && (!m_valid || out_ready);
         acc  = in_valid && rdy;
         cons = m_valid && out_ready;
         dh   = ref_decode(m_held, 0);
         held_load = (m_held[6:0] == 7'h03) && !dh[22];
         haz  = acc && cons && held_load && (m_held[11:7] != 0) &&
                ((needs_rs1(in_ins) && in_ins[19:15] == m_held[11:7]) ||
                 (needs_rs2(in_ins) && in_ins[24:20] == m_held[11:7]));
         d0 = ref_decode(in_ins, 0);
         d1 = ref_decode(in_ins, 1);
         if (acc && d0[22] && m_cnt0 < 15) m_cnt0++;
         if (acc && d1[22] && m_cnt1 < 15) m_cnt1++;
         if (flush) begin m_valid = 0; m_bub = 0; end
         else if (m_bub) begin m_held = m_pend; m_hpc = m_ppc; m_valid = 1; m_bub = 0; end
         else if (haz) begin m_pend = in_ins; m_ppc = in_pc; m_bub = 1; m_valid = 0; end
         else if (acc) begin m_held = in_ins; m_hpc = in_pc; m_valid = 1; end
         else if (cons) m_valid = 0;
      end
   end

   // Per-cycle comparison, sampled mid-cycle
   always @(negedge clk) begin
      bit exp_rdy;
      if (!rst_n) begin
         chk("rst_valid", {vld1, vld0}, 2'b00);
         chk("rst_cnt", {cnt1, cnt0}, 8'h00);
         chk("rst_bundle", {bun1, bun0}, 46'd0);
         chk("rst_fields", {pc0, rs10, rs20, rd0, pc1, rs11, rs21, rd1}, 94'd0);
      end else begin
         exp_rdy = !flush && !m_bub && (!m_valid || out_ready);
         chk("in_ready", {rdy1, rdy0}, {exp_rdy, exp_rdy});
         chk("out_valid", {vld1, vld0}, {m_valid, m_valid});
         chk("illegal_cnt0", cnt0, 64'(m_cnt0));
         chk("illegal_cnt1", cnt1, 64'(m_cnt1));
         if (m_valid) begin
            chk("fields0", {pc0, rs10, rs20, rd0}, {m_hpc, m_held[19:15], m_held[24:20], m_held[11:7]});
            chk("fields1", {pc1, rs11, rs21, rd1}, {m_hpc, m_held[19:15], m_held[24:20], m_held[11:7]});
            chk("bundle0", bun0, ref_decode(m_held, 0));
            chk("bundle1", bun1, ref_decode(m_held, 1));
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl);
      in_valid = v; in_ins = ins; in_pc = pc; out_ready = ordy; flush = fl;
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] c_ADD3  = 32'h002081B3;
   localparam logic [31:0] c_LW5   = 32'h0000A283;
   localparam logic [31:0] c_ADD6  = 32'h00528333;
   localparam logic [31:0] c_MUL   = 32'h022081B3;
   localparam logic [31:0] c_ADDX0 = 32'h00208033;

   logic [31:0] tbl [24];

   initial begin
      tbl = '{32'h123453B7, 32'h00001417, 32'h008000EF, 32'h00008067, 32'h00009067,
              32'h00208463, 32'h00209463, 32'h0020F463, 32'h0020A463, 32'h0020A223,
              32'h00208223, 32'h0020B223, 32'h40208233, 32'h4020D233, 32'h4030D213,
              32'h40309213, 32'h00309213, 32'h0000B283, 32'h0050F493, 32'h4020E233,
              c_LW5, 32'h0050A023, c_LW5, 32'h000012B7};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // add x3,x1,x2: one-cycle latency
      drive(1, c_ADD3, 32'h100, 1, 0);
      chk("add_valid", vld0, 1);
      chk("add_aluop", aluop0, 1);
      chk("add_regwrite", rw0, 1);
      chk("add_regs", {rs10, rs20, rd0}, {5'd1, 5'd2, 5'd3});

      // load-use bubble
      drive(1, c_LW5, 32'h104, 1, 0);
      drive(1, c_ADD6, 32'h108, 1, 0);
      chk("bubble_valid", vld0, 0);
      chk("bubble_ready", rdy0, 0);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("after_bubble", {vld0, rd0, pc0}, {1'b1, 5'd6, 32'h108});

      // mul with and without M extension
      drive(1, c_MUL, 32'h10C, 1, 0);
      chk("mul_m0", bun0, {1'b1, 22'd0});
      chk("mul_m1", {aluop1, rw1, ill1}, {6'd17, 1'b1, 1'b0});
      chk("mul_cnt", {cnt0, cnt1}, {4'd1, 4'd0});

      // flush while bubbling
      drive(1, c_LW5, 32'h110, 1, 0);
      drive(1, c_ADD6, 32'h114, 1, 0);
      drive(0, 32'h0, 32'h0, 1, 1);
      chk("flush_valid", vld0, 0);
      flush = 1'b0;
      #1;
      chk("flush_ready", rdy0, 1);
      drive(0, 32'h0, 32'h0, 1, 0);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("flush_no_emit", vld0, 0);

      // stall with add x0 held
      drive(1, c_ADDX0, 32'h200, 1, 0);
      for (int i = 0; i < 5; i++) drive(1, c_ADD3, 32'h204, 0, 0);
      chk("stall_held", {vld0, pc0, rw0, aluop0}, {1'b1, 32'h200, 1'b0, 6'd1});
      chk("stall_ready", rdy0, 0);
      drive(1, c_ADD3, 32'h204, 1, 0);

      // directed table, then with intermittent backpressure
      for (int i = 0; i < 24; i++) drive(1, tbl[i], 32'h300 + 32'(4 * i), 1, 0);
      drive(1, 32'h0000A003, 32'h400, 1, 0);
      drive(1, 32'h00000333, 32'h404, 1, 0);
      chk("x0_no_hazard", {vld0, rd0}, {1'b1, 5'd6});
      for (int i = 0; i < 24; i++) drive(1, tbl[i], 32'h500 + 32'(4 * i), (i % 3) != 2, 0);
      drive(0, 32'h0, 32'h0, 1, 0);

      // reset mid-stream
      drive(1, c_ADD3, 32'h600, 0, 0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {vld0, pc0}, {1'b0, 32'h0});
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, c_ADD6, 32'h604, 1, 0);
      chk("post_rst", {vld0, pc0, rd0}, {1'b1, 32'h604, 5'd6});

      // counter saturation
      for (int i = 0; i < 19; i++) drive(1, 32'h0000007F, 32'h700, 1, 0);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("cnt_sat", {cnt0, cnt1}, {4'd15, 4'd15});
      drive(0, 32'h0, 32'h0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv32i_decode_stage.md
RV32I_DECODE_STAGE -- requirements
Module: rv32i_decode_stage

Interface
REQ-001 SHALL have parameters, one per line:
- ALUOP_W, default 6, ALUOP field width.
- SRC_W, default 4, ALUSRC1/ALUSRC2 field width.
- M_EXT, default 0, 1 enables RV32M decode.
- STRICT, default 1, 1 checks funct7/funct3 fully.
- CNT_W, default 16, illegal-counter width.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard held and incoming instruction.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_ins  in  32  instruction word.
- in_pc  in  32  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  32  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_jal, out_jalr, out_jumpregwrite, out_branch, out_memwrite, out_memenable, out_regwrite, out_memtoreg  out  1 each  control bits.
- out_aluop  out  ALUOP_W  ALU operation code.
- out_alusrc1, out_alusrc2  out  SRC_W each  ALU operand selects.
- out_illegal  out  1  held instruction is illegal.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-003 SHALL decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP with the package ALUOP and ALUSRC codes.
REQ-004 Codes: ADD=1, SUB=2, SLT=3, SLTU=4, BEQ..BGEU=5..10, AND=11, OR=12, XOR=13, SLL=14, SRL=15, SRA=16; MUL..REMU=17..24 exist only when M_EXT=1.
REQ-005 ALUSRC1 codes: 0=rs1, 1=PC, 2=zero. ALUSRC2 codes: 0=rs2, 1=I-imm, 2=shamt, 3=S-imm, 4=U-imm.
REQ-006 Illegal instruction: unknown opcode, invalid funct3 (branch 010/011; load 011/110/111; store >010), JALR funct3!=000, or, when STRICT=1, any funct7 not listed for the OP/shift-immediate encoding.
REQ-007 OP with funct7=0000001 SHALL be legal only when M_EXT=1.
REQ-008 Illegal instruction: all control bits 0, ALUOP 0, ALUSRC 0, out_illegal 1.
REQ-009 out_regwrite and out_jumpregwrite SHALL be forced to 0 when rd=0.
REQ-010 Output is a one-entry pipeline register; latency from accept to out_valid is 1 cycle.
REQ-011 in_ready = !flush && state==RUN && (!out_valid || out_ready).
REQ-012 The bundle SHALL stay stable while out_valid && !out_ready.
REQ-013 State RUN -> BUBBLE when an instruction is accepted that reads rs1 or rs2 (as the format requires) matching the rd of a held load being consumed this cycle, with rd!=0.
REQ-014 On that hazard the incoming instruction SHALL be captured into a pending register, and out_valid SHALL be 0 for exactly one cycle.
REQ-015 BUBBLE -> RUN next cycle, moving the pending register into the output register with out_valid=1.
REQ-016 Hazard detection: rs2 SHALL count only for OP, BRANCH and STORE; rs1 SHALL not count for LUI, AUIPC or JAL.
REQ-017 flush SHALL clear out_valid and the pending register, force RUN and block acceptance that cycle; flush has priority over hazard, accept and hold.
REQ-018 illegal_cnt SHALL increment on each accepted illegal instruction, SHALL saturate at all-ones, and SHALL not count flushed-same-cycle inputs.

Reset
REQ-019 rst_n low SHALL asynchronously set state=RUN, out_valid=0, pending empty, illegal_cnt=0, and every control, index, PC and code output to 0.
REQ-020 Reset deassertion mid-stream SHALL drop any in-flight bundle; the first accept after release SHALL follow REQ-010.

Structure
REQ-021 ALUOP codes, ALUSRC codes, opcode constants and the state enum SHALL reside in shared package rv32i_pkg.
REQ-022 Combinational decode SHALL be one sub-module, rv32i_decode_comb (instruction in, control bundle plus illegal out), instantiated once and driven by the selected instruction (pending or in_ins).

Verification
REQ-023 0x002081B3 (add x3,x1,x2) accepted -> next cycle out_valid=1, aluop=1, regwrite=1, rs1=1, rs2=2, rd=3.
REQ-024 0x0000A283 (lw x5,0(x1)), then 0x00528333 (add x6,x5,x5) back-to-back with out_ready=1 -> one cycle of out_valid=0, then the add bundle, in_ready=0 during BUBBLE.
REQ-025 0x022081B3 (mul) -> with M_EXT=0: out_illegal=1, all controls 0, illegal_cnt+1; with M_EXT=1: aluop=17, regwrite=1.
REQ-026 0x0000007F repeated 2^CNT_W+3 times (CNT_W=4) -> illegal_cnt holds 15.
REQ-027 flush asserted during BUBBLE -> out_valid=0 next cycle, pending add never emitted, in_ready=1 the cycle after.
REQ-028 out_ready=0 for 5 cycles with add x0,x1,x2 held -> bundle stable, regwrite=0, in_ready=0 throughout.
